// File: rtl/tx_hdmi_pkg.sv
// Shared definitions for the tx_hdmi video transmitter.
// Holds the default 640x480@60 timing constants, the counter and pixel
// widths, the stage-1 control bundle type and the colour-bar table with
// its lookup helper.
package tx_hdmi_pkg;

  // Default horizontal timing, in pixel clocks.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // Default vertical timing, in lines.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 12;   // wide enough for both h and v totals
  localparam int PIX_W = 24;   // {R,G,B} x 8 bits

  // Colour-bar pattern: 8 equal-width bars across the active line.
  localparam int NUM_BARS  = 8;
  localparam int BAR_IDX_W = $clog2(NUM_BARS);
  localparam logic [PIX_W-1:0] BAR_COLOURS [NUM_BARS] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Stage-1 control bundle (sync flags are internal active-high).
  typedef struct packed {
    logic mem_read;
    logic fsync;
    logic hsync;
    logic vsync;
  } ctl_p1_t;

  // Colour for horizontal position x when each bar is bar_w pixels wide.
  // Built from compares rather than a divider; the last bar whose start
  // is at or before x wins.
  function automatic logic [PIX_W-1:0] bar_colour(input int unsigned x,
                                                  input int unsigned bar_w);
    logic [PIX_W-1:0] c;
    c = BAR_COLOURS[0];
    for (int i = 1; i < NUM_BARS; i++) begin
      if (x >= unsigned'(i) * bar_w) c = BAR_COLOURS[BAR_IDX_W'(i)];
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_hdmi_if.sv
// Bus between tx_hdmi, its frame memory and the video sink.
// master: the transmitter (drives Mem_Read and the Out_* video signals).
// slave : the environment (drives SelHDMI and Mem_Data).
//   SelHDMI    source select, 1 = Mem_Data, 0 = colour bars
//   Mem_Data   pixel from memory, valid the cycle after Mem_Read
//   Mem_Read   pixel fetch request
//   Out_pData  video pixel, Out_pHSync/Out_pVSync syncs, Out_pVDE enable
//   FraimSync  one-cycle frame-start pulse
interface tx_hdmi_if import tx_hdmi_pkg::*; ();

  logic             SelHDMI;
  logic [PIX_W-1:0] Mem_Data;
  logic             Mem_Read;
  logic [PIX_W-1:0] Out_pData;
  logic             Out_pHSync;
  logic             Out_pVSync;
  logic             Out_pVDE;
  logic             FraimSync;

  modport master (
    input  SelHDMI, Mem_Data,
    output Mem_Read, Out_pData, Out_pHSync, Out_pVSync, Out_pVDE, FraimSync
  );

  modport slave (
    output SelHDMI, Mem_Data,
    input  Mem_Read, Out_pData, Out_pHSync, Out_pVSync, Out_pVDE, FraimSync
  );

endinterface

// File: rtl/tx_hdmi_timing.sv
// Raster timing generator for tx_hdmi.
// Runs the horizontal/vertical position counters and decodes the raster
// regions from them combinationally (stage 0 of the pipeline).
//   clk           pixel clock
//   rstn          asynchronous, active-high reset; counters return to (0,0)
//   hpos_o        low 10 bits of the horizontal counter (bar indexing)
//   active_o      position is inside the visible area
//   hsync_o       position is inside the horizontal sync pulse (active-high)
//   vsync_o       line is inside the vertical sync pulse (active-high)
//   frame_start_o position is (0,0)
module tx_hdmi_timing import tx_hdmi_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [9:0] hpos_o,
  output logic       active_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  // vcnt only moves on the cycle hcnt wraps.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hpos_o        = hcnt_q[9:0];
  assign active_o      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hsync_o       = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
  // Whole-line vertical sync: depends on vcnt only.
  assign vsync_o       = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
  assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/tx_hdmi.sv
// Video transmitter: raster timing, frame-memory fetch and pixel output.
// Pipeline: stage 0 = counters/decodes, stage 1 = Mem_Read/FraimSync and
// colour-bar lookup, stage 2 = Out_* registers. Memory data requested in
// stage 1 arrives the next cycle and is captured straight into stage 2.
//   clk   pixel clock
//   rstn  asynchronous, active-high reset
//   bus   tx_hdmi_if master: SelHDMI/Mem_Data in, Mem_Read, Out_pData,
//         Out_pHSync, Out_pVSync, Out_pVDE, FraimSync out
module tx_hdmi import tx_hdmi_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic      clk,
  input  logic      rstn,
  tx_hdmi_if.master bus
);

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

  logic [9:0] hpos_p0;
  logic       active_p0;
  logic       hsync_p0;
  logic       vsync_p0;
  logic       frame_start_p0;

  tx_hdmi_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .rstn          (rstn),
    .hpos_o        (hpos_p0),
    .active_o      (active_p0),
    .hsync_o       (hsync_p0),
    .vsync_o       (vsync_p0),
    .frame_start_o (frame_start_p0)
  );

  // ---- stage 0 -> stage 1 ----
  ctl_p1_t          ctl_p1_q, ctl_p1_d;
  logic [PIX_W-1:0] bar_p1_q;
  logic             sel_q;

  always_comb begin
    ctl_p1_d          = '0;
    ctl_p1_d.mem_read = active_p0;
    ctl_p1_d.fsync    = frame_start_p0;
    ctl_p1_d.hsync    = hsync_p0;
    ctl_p1_d.vsync    = vsync_p0;
  end

  // The source select is captured only at frame start, so a whole frame
  // always comes from one source.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ctl_p1_q <= '0;
      sel_q    <= 1'b1;
    end else begin
      ctl_p1_q <= ctl_p1_d;
      if (frame_start_p0) sel_q <= bus.SelHDMI;
    end
  end

  // Bar colour is pure data; it is only consumed while mem_read is set.
  always_ff @(posedge clk) begin
    bar_p1_q <= bar_colour(32'(hpos_p0), BAR_W);
  end

  // ---- stage 1 -> stage 2 ----
  logic [PIX_W-1:0] data_p2_q, data_p2_d;
  logic             vld_p2_q;
  logic             hsync_p2_q;
  logic             vsync_p2_q;

  always_comb begin
    data_p2_d = '0;
    if (ctl_p1_q.mem_read) data_p2_d = sel_q ? bus.Mem_Data : bar_p1_q;
  end

  // Blanking data is forced to zero, so the data register is reset too.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      vld_p2_q   <= 1'b0;
      hsync_p2_q <= ~SYNC_POL;
      vsync_p2_q <= ~SYNC_POL;
      data_p2_q  <= '0;
    end else begin
      vld_p2_q   <= ctl_p1_q.mem_read;
      hsync_p2_q <= ctl_p1_q.hsync ? SYNC_POL : ~SYNC_POL;
      vsync_p2_q <= ctl_p1_q.vsync ? SYNC_POL : ~SYNC_POL;
      data_p2_q  <= data_p2_d;
    end
  end

  assign bus.Mem_Read   = ctl_p1_q.mem_read;
  assign bus.FraimSync  = ctl_p1_q.fsync;
  assign bus.Out_pVDE   = vld_p2_q;
  assign bus.Out_pHSync = hsync_p2_q;
  assign bus.Out_pVSync = vsync_p2_q;
  assign bus.Out_pData  = data_p2_q;

endmodule

// File: tb/tb_tx_hdmi.sv
// Scoreboard bench for tx_hdmi on a reduced raster (48x15, 720 cycles per
// frame). A reference process pushes the expected per-cycle control state
// and expected pixels; a monitor pops and compares them against the DUT.
module tb_tx_hdmi;

  localparam int HA = 32, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 48
  localparam int VT = VA + VFP + VSW + VBP;   // 15
  localparam int F  = HT * VT;                // 720
  localparam int BW = HA / 8;                 // 4
  localparam bit POL = 1'b0;

  typedef struct {
    bit mr;
    bit fs;
    bit vde;
    bit hs;
    bit vs;
  } ctl_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  tx_hdmi_if bus ();

  tx_hdmi #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SYNC_POL (POL)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  ctl_t        ctl_q[$];
  logic [23:0] pix_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
  endtask

  // Reference raster: position p counts pixel clocks from frame start.
  function automatic int hc(int p); return (p % F) % HT; endfunction
  function automatic int vc(int p); return (p % F) / HT; endfunction
  function automatic bit act(int p); return (hc(p) < HA) && (vc(p) < VA); endfunction
  function automatic bit hsa(int p); return (hc(p) >= HA + HFP) && (hc(p) < HA + HFP + HSW); endfunction
  function automatic bit vsa(int p); return (vc(p) >= VA + VFP) && (vc(p) < VA + VFP + VSW); endfunction

  function automatic logic [23:0] exp_pix(int p, bit sel);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (sel) return {8'h00, 8'(vc(p)), 8'(hc(p))};
    return bars[3'(hc(p) / BW)];
  endfunction

  // Edge counter since reset release and the model of the latched select.
  int e = 0;
  bit sel_m = 1'b1;

  always @(posedge clk) begin
    if (rstn) begin
      e = 0;
      sel_m = 1'b1;
    end else begin
      e = e + 1;
      if ((e - 1) % F == 0) sel_m = bus.SelHDMI;
    end
  end

  // Expected state after edge e: stage 1 shows position e-1, stage 2 e-2.
  always @(negedge clk) begin
    ctl_t c;
    c = '{mr: 1'b0, fs: 1'b0, vde: 1'b0, hs: ~POL, vs: ~POL};
    if (!rstn && e > 0) begin
      c.mr = act(e - 1);
      c.fs = ((e - 1) % F) == 0;
      if (e >= 2) begin
        c.vde = act(e - 2);
        c.hs  = hsa(e - 2) ? POL : ~POL;
        c.vs  = vsa(e - 2) ? POL : ~POL;
        if (c.vde) pix_q.push_back(exp_pix(e - 2, sel_m));
      end
    end
    ctl_q.push_back(c);
  end

  // Frame memory: serves a {line, pixel} ramp in read order.
  int rd = 0;
  always @(negedge clk) begin
    if (rstn) begin
      rd = 0;
      bus.Mem_Data = '0;
    end else if (bus.Mem_Read) begin
      bus.Mem_Data = {8'h00, 8'((rd / HA) % VA), 8'(rd % HA)};
      rd = rd + 1;
    end
  end

  // Monitor: per-cycle scoreboard plus frame/line interval checks.
  int cyc = 0;
  int fs_last = -1, vde_rise = -1, hs_start = -1;
  int mr_cnt = 0, vs_cnt = 0;
  bit vde_prev = 1'b0, hs_prev = 1'b0;

  always @(negedge clk) begin
    ctl_t c;
    bit hs_on;
    #1;
    cyc++;
    if (ctl_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL ctl_queue t=%0t got empty want entry", $time);
    end else begin
      c = ctl_q.pop_front();
      check("mem_read",  32'(bus.Mem_Read),   32'(c.mr));
      check("fraimsync", 32'(bus.FraimSync),  32'(c.fs));
      check("vde",       32'(bus.Out_pVDE),   32'(c.vde));
      check("hsync",     32'(bus.Out_pHSync), 32'(c.hs));
      check("vsync",     32'(bus.Out_pVSync), 32'(c.vs));
    end
    if (bus.Out_pVDE) begin
      if (pix_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL pixel_queue t=%0t got empty want entry", $time);
      end else begin
        check("pixel", 32'(bus.Out_pData), 32'(pix_q.pop_front()));
      end
    end else begin
      check("blank_data", 32'(bus.Out_pData), 32'h0);
    end

    if (rstn) begin
      fs_last = -1; vde_rise = -1; hs_start = -1;
      mr_cnt = 0; vs_cnt = 0; vde_prev = 1'b0; hs_prev = 1'b0;
    end else begin
      if (bus.FraimSync) begin
        if (fs_last >= 0) begin
          check("frame_period",   32'(cyc - fs_last), 32'(F));
          check("reads_per_frame", 32'(mr_cnt), 32'(HA * VA));
          check("vsync_per_frame", 32'(vs_cnt), 32'(VSW * HT));
        end
        fs_last = cyc; mr_cnt = 0; vs_cnt = 0;
      end
      if (bus.Mem_Read) mr_cnt++;
      if (bus.Out_pVSync == POL) vs_cnt++;
      hs_on = (bus.Out_pHSync == POL);
      if (bus.Out_pVDE && !vde_prev) vde_rise = cyc;
      if (hs_on && !hs_prev) begin
        hs_start = cyc;
        if (vde_rise >= 0 && cyc - vde_rise < HT)
          check("hsync_offset", 32'(cyc - vde_rise), 32'(HA + HFP));
      end
      if (!hs_on && hs_prev && hs_start >= 0)
        check("hsync_width", 32'(cyc - hs_start), 32'(HSW));
      vde_prev = bus.Out_pVDE;
      hs_prev = hs_on;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bus.SelHDMI = 1'b1;
    bus.Mem_Data = '0;
    #1 rstn = 1'b1;
    step(4);
    rstn = 1'b0;                 // frame 1 from memory
    step(F / 2);
    bus.SelHDMI = 1'b0;          // mid-frame: takes effect at frame 2
    step(F);
    bus.SelHDMI = 1'b1;          // mid-frame 2 (bars): memory again at frame 3
    step(F / 2 + 4 * HT + 10);
    rstn = 1'b1;                 // abort frame 3 at line 4
    step(3);
    rstn = 1'b0;                 // restart from (0,0)
    step(F + F / 2);
    bus.SelHDMI = 1'b0;
    step(F);                     // bars frame after the restart
    check("pixel_queue_drained", 32'(pix_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
